cache_linefill: RTL

- Line-fill engine: the writer side of the 256-bit two-port cache RAM (256 lines, 8 x 32-bit words per line).
- On a cache miss it fetches one line from external memory as a wrapping 8-word burst, critical word first.
- It forwards the critical word to the core, assembles the full line, then issues a single-cycle write on the cache RAM write port (write_sel / write_port / wr_ena).

---
 rtl/cache_linefill_pkg.sv | 16 +
 rtl/cache_linefill_if.sv | 11 +
 rtl/cache_linefill_buf.sv | 27 ++
 rtl/cache_linefill.sv | 113 +++++++++++
 4 files changed

// File: rtl/cache_linefill_pkg.sv
// Shared definitions for the cache line-fill engine: FSM encoding and line geometry.
package cache_linefill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } lf_state_t;

  localparam int WORDS_PER_LINE = 8;
  localparam int WORD_BITS      = 32;
  localparam int LINE_BITS      = WORDS_PER_LINE * WORD_BITS;
  localparam int WIDX_BITS      = 3;

endpackage

// File: rtl/cache_linefill_if.sv
// Burst read bus between the line-fill engine (master) and external memory (slave).
interface cache_linefill_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        mem_err;

  modport master (output mem_req, mem_addr, input mem_ack, mem_data, mem_err);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_data, mem_err);
endinterface

// File: rtl/cache_linefill_buf.sv
// 8 x 32-bit line assembly buffer with indexed write and a flat line view.
module cache_linefill_buf
  import cache_linefill_pkg::*;
(
  input  logic                 nGCLK,
  input  logic                 nRESET,
  input  logic                 wr_en,
  input  logic [WIDX_BITS-1:0] wr_idx,
  input  logic [WORD_BITS-1:0] wr_data,
  output logic [LINE_BITS-1:0] line_flat
);

  logic [WORD_BITS-1:0] word_q [WORDS_PER_LINE];

  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int n = 0; n < WORDS_PER_LINE; n++) word_q[n] <= '0;
    end else if (wr_en) begin
      word_q[wr_idx] <= wr_data;
    end
  end

  for (genvar g = 0; g < WORDS_PER_LINE; g++) begin : g_flat
    assign line_flat[g*WORD_BITS +: WORD_BITS] = word_q[g];
  end

endmodule

// File: rtl/cache_linefill.sv
// Cache line-fill engine: wrapping critical-word-first burst, line assembly, single-cycle RAM write.
//   state | meaning
//   IDLE  | waiting for fill_req
//   BURST | requesting words s, s+1, ... (mod 8) until 8 acks or mem_err
//   WRITE | wr_ena pulse with the assembled line
//   DONE  | fill_done pulse, line already committed
module cache_linefill
  import cache_linefill_pkg::*;
#(
  parameter int NL  = 256,
  parameter int LSS = $clog2(NL)
) (
  input  logic                 nGCLK,
  input  logic                 nRESET,
  input  logic                 fill_req,
  input  logic [31:0]          fill_addr,
  output logic                 fill_busy,
  cache_linefill_if.master     mem,
  output logic                 crit_valid,
  output logic [WORD_BITS-1:0] crit_data,
  output logic [LSS-1:0]       write_sel,
  output logic [LINE_BITS-1:0] write_port,
  output logic                 wr_ena,
  output logic                 fill_done,
  output logic                 fill_err
);

  lf_state_t            state_q, state_d;
  logic [26:0]          base_q;
  logic [WIDX_BITS-1:0] idx_q;
  logic [WIDX_BITS-1:0] cnt_q;
  logic [LINE_BITS-1:0] buf_flat;
  logic                 beat_ok, beat_err, last_beat;
  logic                 unused_addr_lsb;

  assign unused_addr_lsb = ^fill_addr[1:0];

  // mem_err wins over a same-cycle ack, so errored data never reaches the buffer
  assign beat_err  = (state_q == ST_BURST) && mem.mem_err;
  assign beat_ok   = (state_q == ST_BURST) && mem.mem_ack && !mem.mem_err;
  assign last_beat = beat_ok && (cnt_q == 3'd7);

  cache_linefill_buf u_buf (
    .nGCLK     (nGCLK),
    .nRESET    (nRESET),
    .wr_en     (beat_ok),
    .wr_idx    (idx_q),
    .wr_data   (mem.mem_data),
    .line_flat (buf_flat)
  );

  always_comb begin
    state_d      = state_q;
    mem.mem_req  = 1'b0;
    mem.mem_addr = '0;
    wr_ena       = 1'b0;
    fill_done    = 1'b0;
    fill_busy    = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE:  if (fill_req) state_d = ST_BURST;
      ST_BURST: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = {base_q, idx_q, 2'b00};
        if (mem.mem_err)                         state_d = ST_IDLE;
        else if (mem.mem_ack && cnt_q == 3'd7)   state_d = ST_WRITE;
      end
      ST_WRITE: begin
        wr_ena  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        fill_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      crit_valid <= 1'b0;
      crit_data  <= '0;
      fill_err   <= 1'b0;
      write_sel  <= '0;
      write_port <= '0;
    end else begin
      state_q    <= state_d;
      crit_valid <= beat_ok && (cnt_q == 3'd0);
      fill_err   <= beat_err;
      if (state_q == ST_IDLE && fill_req) begin
        base_q <= fill_addr[31:5];
        idx_q  <= fill_addr[4:2];
        cnt_q  <= '0;
      end
      if (beat_ok) begin
        idx_q <= idx_q + 3'd1;
        cnt_q <= cnt_q + 3'd1;
      end
      if (beat_ok && cnt_q == 3'd0) crit_data <= mem.mem_data;
      // Output line is captured with the final beat merged in so it is whole in WRITE and holds afterwards
      if (last_beat) begin
        write_sel                              <= base_q[LSS-1:0];
        write_port                             <= buf_flat;
        write_port[{idx_q, 5'd0} +: WORD_BITS] <= mem.mem_data;
      end
    end
  end

endmodule
